// File: rtl/key_debounce_array.sv
// N-channel push-button debouncer: per key a 2-flop synchroniser and a four-state
// settle FSM producing a debounced level plus registered press, release and long-press pulses.
module key_debounce_array #(
    parameter int N_KEYS       = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 30,
    parameter int LONG_CYC     = 1000,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_P  = 2'd1,
        PRESSED = 2'd2,
        WAIT_R  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'((LONG_CYC == 0) ? 0 : LONG_CYC - 1);
    localparam logic             RELEASED  = ACTIVE_LOW;
    localparam bit               LONG_EN   = (LONG_CYC != 0);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        logic             sync1, sync2;
        logic             act;
        state_t           state;
        logic [CNT_W-1:0] cnt, lcnt;
        logic             long_done;
        logic             level, pp, rp, lp;

        assign act = sync2 ^ ACTIVE_LOW;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1     <= RELEASED;
                sync2     <= RELEASED;
                state     <= IDLE;
                cnt       <= '0;
                lcnt      <= '0;
                long_done <= 1'b0;
                level     <= 1'b0;
                pp        <= 1'b0;
                rp        <= 1'b0;
                lp        <= 1'b0;
            end else begin
                sync1 <= key_in[g];
                sync2 <= sync1;
                // Pulses are single-cycle: cleared every cycle unless a transition below sets them.
                pp    <= 1'b0;
                rp    <= 1'b0;
                lp    <= 1'b0;
                case (state)
                    IDLE: begin
                        if (act) begin
                            state <= WAIT_P;
                            cnt   <= '0;
                        end
                    end
                    WAIT_P: begin
                        if (!act) begin
                            state <= IDLE;
                        end else if (cnt == DB_LAST) begin
                            state     <= PRESSED;
                            level     <= 1'b1;
                            pp        <= 1'b1;
                            cnt       <= '0;
                            lcnt      <= '0;
                            long_done <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!act) begin
                            state <= WAIT_R;
                            cnt   <= '0;
                        end else if (LONG_EN && !long_done) begin
                            if (lcnt == LONG_LAST) begin
                                lp        <= 1'b1;
                                long_done <= 1'b1;
                            end else begin
                                lcnt <= lcnt + 1'b1;
                            end
                        end
                    end
                    WAIT_R: begin
                        // A release bounce returns to PRESSED keeping lcnt/long_done intact.
                        if (act) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state <= IDLE;
                            level <= 1'b0;
                            rp    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // NOTE: explicit default recovers from any illegal encoding instead of relying on the enum.
                    default: begin
                        state <= IDLE;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign key_pressed[g]   = level;
        assign press_pulse[g]   = pp;
        assign release_pulse[g] = rp;
        assign long_pulse[g]    = lp;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: an active-low and an active-high instance driven with
// mirrored stimulus, both checked every cycle against a run-length debounce model.
module tb_key_debounce_array;

    localparam int N = 4;
    localparam int D = 30;
    localparam int L = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] press;
    logic [N-1:0] kp_lo, pp_lo, rp_lo, lp_lo;
    logic [N-1:0] kp_hi, pp_hi, rp_hi, lp_hi;

    always #5 clk = ~clk;

    key_debounce_array #(.N_KEYS(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(D), .LONG_CYC(L), .CNT_W(16)) dut_lo (
        .clk(clk), .rst(rst), .key_in(~press),
        .key_pressed(kp_lo), .press_pulse(pp_lo), .release_pulse(rp_lo), .long_pulse(lp_lo)
    );

    key_debounce_array #(.N_KEYS(N), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(D), .LONG_CYC(L), .CNT_W(16)) dut_hi (
        .clk(clk), .rst(rst), .key_in(press),
        .key_pressed(kp_hi), .press_pulse(pp_hi), .release_pulse(rp_hi), .long_pulse(lp_hi)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once D+1 consecutive synchronised
    // samples disagree with it; the synchroniser is a two-sample delay.
    bit [N-1:0] h0, h1, lvl, done;
    int         run  [N];
    int         held [N];
    logic [N-1:0] e_pp, e_rp, e_lp;

    task automatic model_step();
        bit a;
        e_pp = '0;
        e_rp = '0;
        e_lp = '0;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                h0[i] = 0; h1[i] = 0; lvl[i] = 0; done[i] = 0;
                run[i] = 0; held[i] = 0;
            end else begin
                a     = h1[i];
                h1[i] = h0[i];
                h0[i] = press[i];
                if (a != lvl[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        lvl[i] = a;
                        run[i] = 0;
                        if (a) begin
                            e_pp[i] = 1'b1;
                            held[i] = 0;
                            done[i] = 0;
                        end else begin
                            e_rp[i] = 1'b1;
                        end
                    end
                end else begin
                    // A held sample counts toward long-press only if no release bounce preceded it.
                    if (lvl[i] && run[i] == 0 && L != 0 && !done[i]) begin
                        held[i]++;
                        if (held[i] == L) begin
                            e_lp[i] = 1'b1;
                            done[i] = 1;
                        end
                    end
                    run[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("kp_lo", 32'(kp_lo), 32'(lvl));
        check("pp_lo", 32'(pp_lo), 32'(e_pp));
        check("rp_lo", 32'(rp_lo), 32'(e_rp));
        check("lp_lo", 32'(lp_lo), 32'(e_lp));
        check("kp_hi", 32'(kp_hi), 32'(lvl));
        check("pp_hi", 32'(pp_hi), 32'(e_pp));
        check("rp_hi", 32'(rp_hi), 32'(e_rp));
        check("lp_hi", 32'(lp_hi), 32'(e_lp));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int  cnt_rp, cnt_lp, lp_at, quiet;
        bit  seen;

        rst   = 1'b1;
        press = '0;
        steps(2);
        check("rst_kp", 32'(kp_lo | kp_hi), 32'd0);
        rst = 1'b0;
        steps(3);

        // Single press: level and pulse on edge D+3, pulse gone next edge.
        press[0] = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k == 33) begin
                check("t1_kp0", 32'(kp_lo[0]), 32'd1);
                check("t1_pp0", 32'(pp_lo[0]), 32'd1);
                check("t1_others", 32'(kp_lo[3:1]), 32'd0);
            end
            if (k == 34) check("t1_pp0_low", 32'(pp_lo[0]), 32'd0);
        end
        press[0] = 1'b0;
        steps(40);

        // Short glitch rejected.
        quiet    = 0;
        press[1] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k == 20) press[1] = 1'b0;
            step();
            quiet |= int'(kp_lo[1] | pp_lo[1] | rp_lo[1] | kp_hi[1] | pp_hi[1] | rp_hi[1]);
        end
        check("t2_quiet", 32'(quiet), 32'd0);

        // Release bounce mid-hold, then a clean release.
        press[2] = 1'b1;
        steps(40);
        cnt_rp = 0;
        for (int k = 0; k < 50; k++) begin
            press[2] = (k >= 10);
            step();
            cnt_rp += int'(rp_lo[2]);
        end
        check("t3_no_rel", 32'(cnt_rp), 32'd0);
        check("t3_held", 32'(kp_lo[2]), 32'd1);
        press[2] = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k == 32) check("t3_rel_early", 32'(rp_lo[2]), 32'd0);
            if (k == 33) check("t3_rel", 32'(rp_lo[2]), 32'd1);
        end
        steps(5);

        // Long press fires once, L cycles after press_pulse.
        press[3] = 1'b1;
        seen     = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            seen = pp_lo[3];
        end
        check("t4_press_seen", 32'(seen), 32'd1);
        cnt_lp = 0;
        lp_at  = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (lp_lo[3]) begin
                cnt_lp++;
                lp_at = k;
            end
        end
        check("t4_lp_count", 32'(cnt_lp), 32'd1);
        check("t4_lp_at", 32'(lp_at), 32'd100);
        press[3] = 1'b0;
        steps(40);

        // Reset mid-count and mid-hold.
        press[1] = 1'b1;
        steps(40);
        press[0] = 1'b1;
        steps(18);
        rst = 1'b1;
        step();
        check("t5_rst_lo", 32'({kp_lo, pp_lo, rp_lo, lp_lo}), 32'd0);
        check("t5_rst_hi", 32'({kp_hi, pp_hi, rp_hi, lp_hi}), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 32) check("t5_pp_early", 32'(pp_lo[1]), 32'd0);
            if (k == 33) begin
                check("t5_pp_lo", 32'(pp_lo[1]), 32'd1);
                check("t5_pp_hi", 32'(pp_hi[1]), 32'd1);
            end
        end
        press = '0;
        steps(40);

        // Simultaneous press on keys 0 and 3, both polarities.
        press = 4'b1001;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 33) begin
                check("t6_pp_lo", 32'(pp_lo), 32'h9);
                check("t6_pp_hi", 32'(pp_hi), 32'h9);
            end
        end
        press = '0;
        steps(40);

        // Randomised segments with bounces, long holds and occasional resets.
        for (int s = 0; s < 80; s++) begin
            int hold;
            press = N'($urandom);
            hold  = int'($urandom_range(1, 140));
            for (int k = 0; k < hold; k++) begin
                rst = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 19) == 0) press[$urandom_range(0, N - 1)] ^= 1'b1;
                step();
            end
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
